lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit between the MEM stage of the pipelined core and the byte-enabled data memory. It is the sequential successor to the combinational access-pattern and load-extract gadgets, and is parametrised in data width. It turns one load or store request of any size at any byte address into one or two aligned memory beats with byte enables. Read data is shifted, merged across beats and sign- or zero-extended before it is returned to the pipeline.

## Interface
- XLEN, 32: data width; 32 or 64 only.
- ADDR_W, 32: address width.
- NB = XLEN/8, derived: byte lanes. OFF_W = log2(NB).
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 double
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- mem_valid  out  1  beat presented
- mem_ready  in  1  beat accepted when mem_valid & mem_ready
- mem_write  out  1  beat is a write
- mem_addr  out  ADDR_W  aligned beat address; low OFF_W bits are 0
- mem_be  out  NB  byte enables
- mem_wdata  out  XLEN  lane-positioned write data
- mem_rdata  in  XLEN  read data, valid exactly one cycle after an accepted read beat
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores
- resp_err  out  1  unsupported size

## Operation
- Latch the request on acceptance. Derive the following from it:
  - off = addr[OFF_W-1:0]
  - nbytes = 1<<size
  - split = (off + nbytes > NB)
- Error case: size 3 with XLEN=32.
  - No beats are issued.
  - Go to RSP with resp_err=1 and resp_rdata=0.
- States: IDLE, B0, B1, WAIT, RSP.
- IDLE:
  - req_ready=1.
  - On accept, go to B0 (or RSP on error).
- B0:
  - mem_addr = addr & ~(NB-1).
  - mem_be = lower NB bits of (((1<<nbytes)-1) << off).
  - mem_wdata = wdata << 8*off.
  - On accept: go to B1 if split. Otherwise go to WAIT for a load, or RSP for a store.
- B1:
  - mem_addr = B0 address + NB, modulo 2^ADDR_W, so the address wraps to 0.
  - mem_be = the remaining upper bits of the 2*NB-bit enable mask.
  - mem_wdata = upper XLEN bits of the 2*XLEN-bit shifted data.
  - On accept, go to WAIT for a load, or RSP for a store.
- Beat-0 read capture: a registered pending flag captures mem_rdata into beat0_q in the cycle after the B0 read accept. This happens regardless of the current state or of mem_ready.
- WAIT (load only): merge the two beats and register the result into resp_rdata.
  - Split access: merged = {mem_rdata, beat0_q}.
  - Non-split access: merged = {0, mem_rdata}.
  - result = merged >> 8*off, truncated to nbytes, then sign- or zero-extended per req_unsigned.
  - Next state is RSP.
- RSP:
  - resp_valid=1 for one cycle.
  - Go to IDLE.
  - resp_rdata and resp_err hold until the next request completes.
- While mem_valid=1 and mem_ready=0, mem_addr, mem_be, mem_wdata and mem_write are held stable.

## Timing
- Reset values: state IDLE, req_ready=1, all other outputs 0, beat0_q=0, pending flag=0.
- Reset mid-operation: the access is aborted and any in-flight beat is discarded. Outputs return to the reset values; memory-side cleanup is the memory's responsibility.
- Latency from the accept cycle T, assuming mem_ready=1:
  - Aligned load: B0 at T+1, WAIT at T+2, resp_valid at T+3.
  - Split load: resp_valid at T+4.
  - Aligned store: resp_valid at T+2.
  - Split store: resp_valid at T+3.
  - Error: resp_valid at T+1.
- Each cycle of mem_ready=0 adds one cycle of latency.
- One outstanding request at a time. req_ready=0 in every state other than IDLE, so a new request can be accepted no earlier than the cycle after RSP.
- No resp_ready: the pipeline must take the response in the resp_valid cycle.

## Structure
- Package lsu_pkg holds:
  - Size encodings: SZ_B, SZ_H, SZ_W, SZ_D.
  - State enum: IDLE, B0, B1, WAIT, RSP.
- Sub-module lsu_extend, combinational, parametrised by XLEN. Inputs: the 2*XLEN merged data, off, size, unsigned. Output: the XLEN result. It generalises the fixed-width load extractor.

## Test plan
- Aligned load: lw at 0x100, mem_rdata 0xDEADBEEF -> one beat at 0x100 with be 1111; resp_rdata 0xDEADBEEF at T+3.
- Byte loads: lb at 0x103 with rdata 0x80123456 -> be 1000, resp 0xFFFFFF80. lbu at the same address -> resp 0x00000080.
- Split load: lw at 0x0FE.
  - Beat 0: address 0x0FC, be 1100, rdata 0xBBAA0000.
  - Beat 1: address 0x100, be 0011, rdata 0x0000DDCC.
  - Response: 0xDDCCBBAA at T+4.
- Split store: sh at 0x0FF with wdata 0x1234.
  - Beat 0: address 0x0FC, be 1000, wdata 0x34000000.
  - Beat 1: address 0x100, be 0001, wdata 0x00000012.
  - resp_valid at T+3 with resp_rdata 0.
- Stall: split lw with mem_ready held low for 3 cycles in B1 -> B1 outputs stay stable, beat0_q is preserved, the result is correct, and resp_valid comes 3 cycles later.
- Reset and error:
  - Assert reset during B1 -> the next cycle shows mem_valid=0 and req_ready=1.
  - A size-3 request with XLEN=32 -> no beats, resp_err=1 at T+1.
  - sw at 0xFFFFFFFE -> beat 1 address wraps to 0x00000000.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store alignment unit: access sizes,
// controller states and a small size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        WAIT = 3'd3,
        RSP  = 3'd4
    } lsu_state_e;

    // Number of bytes moved by an access of the given size code.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Pipeline request/response and data-memory beat signals of lsu_align.
// The slave modport is the alignment unit; the master modport is the
// surrounding environment (pipeline plus memory).
interface lsu_align_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output mem_valid, mem_write, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  mem_valid, mem_write, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata,
        input  resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_extend.sv
// Load data extractor: shifts the two-beat merged read data down to the
// addressed byte, keeps the accessed bytes and sign- or zero-extends them.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] merged_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [XLEN-1:0]   result_o
);

    logic [OFF_W+2:0] shamt_s;
    logic [XLEN-1:0]  lo_s;
    logic [XLEN-1:0]  mask_s;
    logic             sgn_s;

    // Align the addressed byte to bit 0, then mask and extend by size.
    always_comb begin
        shamt_s = {off_i, 3'b000};
        lo_s    = XLEN'(merged_i >> shamt_s);
        case (size_i)
            SZ_B: begin
                mask_s = XLEN'(8'hFF);
                sgn_s  = lo_s[7];
            end
            SZ_H: begin
                mask_s = XLEN'(16'hFFFF);
                sgn_s  = lo_s[15];
            end
            SZ_W: begin
                mask_s = XLEN'(32'hFFFF_FFFF);
                sgn_s  = lo_s[31];
            end
            default: begin
                mask_s = {XLEN{1'b1}};
                sgn_s  = lo_s[XLEN-1];
            end
        endcase
        result_o = (lo_s & mask_s) |
                   ((sgn_s && !unsigned_i) ? ~mask_s : {XLEN{1'b0}});
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: splits one request of any size at any byte
// address into one or two aligned, byte-enabled memory beats and returns
// merged, extended load data as a one-cycle response pulse.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    lsu_align_if.slave bus
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    // Doubleword accesses do not exist on a 32-bit datapath.
    localparam logic NO_DBL = (XLEN == 32);

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              write_q, write_d;
    logic              split_q, split_d;
    logic [ADDR_W-1:0] b1_addr_q, b1_addr_d;
    logic [NB-1:0]     b1_be_q, b1_be_d;
    logic [XLEN-1:0]   b1_wdata_q, b1_wdata_d;
    logic              pend_q, pend_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;

    logic [OFF_W-1:0]  off_s;
    logic [3:0]        nbytes_s;
    logic              split_s;
    logic              err_s;
    logic [ADDR_W-1:0] base_s;
    logic [15:0]       mask16_s;
    logic [2*NB-1:0]   be_full_s;
    logic [2*XLEN-1:0] wsh_s;
    logic [2*XLEN-1:0] merged_s;
    logic [XLEN-1:0]   ext_s;

    // Decode the incoming request into beat addresses, enables and lane data.
    always_comb begin
        off_s     = bus.req_addr[OFF_W-1:0];
        nbytes_s  = size_bytes(bus.req_size);
        split_s   = (5'(off_s) + 5'(nbytes_s)) > 5'(NB);
        err_s     = (bus.req_size == SZ_D) && NO_DBL;
        base_s    = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mask16_s  = (16'd1 << nbytes_s) - 16'd1;
        be_full_s = (2*NB)'(mask16_s << off_s);
        wsh_s     = {{XLEN{1'b0}}, bus.req_wdata} << {off_s, 3'b000};
        merged_s  = split_q ? {bus.mem_rdata, beat0_q} : {{XLEN{1'b0}}, bus.mem_rdata};
    end

    lsu_extend #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extend (
        .merged_i   (merged_s),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ext_s)
    );

    // Controller: sequence beats, capture beat-0 read data, build the response.
    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        write_d      = write_q;
        split_d      = split_q;
        b1_addr_d    = b1_addr_q;
        b1_be_d      = b1_be_q;
        b1_wdata_d   = b1_wdata_q;
        // Beat-0 read data arrives the cycle after its accept, whatever the state.
        pend_d       = (state_q == B0) && bus.mem_ready && !write_q;
        beat0_d      = pend_q ? bus.mem_rdata : beat0_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    off_d      = off_s;
                    size_d     = bus.req_size;
                    uns_d      = bus.req_unsigned;
                    write_d    = bus.req_write;
                    split_d    = split_s;
                    b1_addr_d  = base_s + ADDR_W'(NB);
                    b1_be_d    = be_full_s[2*NB-1:NB];
                    b1_wdata_d = wsh_s[2*XLEN-1:XLEN];
                    if (err_s) begin
                        state_d      = RSP;
                        resp_rdata_d = {XLEN{1'b0}};
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = B0;
                        mem_valid_d = 1'b1;
                        mem_write_d = bus.req_write;
                        mem_addr_d  = base_s;
                        mem_be_d    = be_full_s[NB-1:0];
                        mem_wdata_d = wsh_s[XLEN-1:0];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            B0: begin
                if (bus.mem_ready) begin
                    if (split_q) begin
                        state_d     = B1;
                        mem_addr_d  = b1_addr_q;
                        mem_be_d    = b1_be_q;
                        mem_wdata_d = b1_wdata_q;
                    end else if (write_q) begin
                        state_d      = RSP;
                        mem_valid_d  = 1'b0;
                        mem_write_d  = 1'b0;
                        mem_be_d     = {NB{1'b0}};
                        resp_rdata_d = {XLEN{1'b0}};
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d     = WAIT;
                        mem_valid_d = 1'b0;
                        mem_be_d    = {NB{1'b0}};
                    end
                end else begin
                    state_d = B0;
                end
            end
            B1: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_write_d = 1'b0;
                    mem_be_d    = {NB{1'b0}};
                    if (write_q) begin
                        state_d      = RSP;
                        resp_rdata_d = {XLEN{1'b0}};
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = B1;
                end
            end
            WAIT: begin
                state_d      = RSP;
                resp_rdata_d = ext_s;
                resp_err_d   = 1'b0;
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RSP);
    end

    // State, output and request-context registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_be_q     <= {NB{1'b0}};
            mem_wdata_q  <= {XLEN{1'b0}};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {XLEN{1'b0}};
            resp_err_q   <= 1'b0;
            off_q        <= {OFF_W{1'b0}};
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
            split_q      <= 1'b0;
            b1_addr_q    <= {ADDR_W{1'b0}};
            b1_be_q      <= {NB{1'b0}};
            b1_wdata_q   <= {XLEN{1'b0}};
            pend_q       <= 1'b0;
            beat0_q      <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            write_q      <= write_d;
            split_q      <= split_d;
            b1_addr_q    <= b1_addr_d;
            b1_be_q      <= b1_be_d;
            b1_wdata_q   <= b1_wdata_d;
            pend_q       <= pend_d;
            beat0_q      <= beat0_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align (XLEN=32): directed requests push expected
// beats and responses; a negedge monitor checks every presented beat and
// response against the queue heads, and a responder returns read data.
module tb_lsu_align;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_err;

    beat_t beat_q[$];
    resp_t resp_q[$];
    logic        rd_pend;
    logic [31:0] rd_val;

    lsu_align_if #(.XLEN(32), .ADDR_W(32)) bus ();

    lsu_align #(.XLEN(32), .ADDR_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory read-data responder: data appears the cycle after a read accept.
    initial begin
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend) begin
                bus.mem_rdata = rd_val;
                rd_pend = 1'b0;
            end else begin
                bus.mem_rdata = 32'hA5A5_A5A5;
            end
        end
    end

    // Monitor: every presented beat and response is compared to the queue head.
    initial begin
        beat_t b;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.mem_valid) begin
                    if (beat_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_beat: got addr %h be %b, none expected", bus.mem_addr, bus.mem_be);
                    end else begin
                        b = beat_q[0];
                        chk("beat_addr",  64'(bus.mem_addr),  64'(b.addr));
                        chk("beat_be",    64'(bus.mem_be),    64'(b.be));
                        chk("beat_write", 64'(bus.mem_write), 64'(b.wr));
                        chk("beat_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
                        if (bus.mem_ready) begin
                            void'(beat_q.pop_front());
                            if (!b.wr) begin
                                rd_pend = 1'b1;
                                rd_val  = b.rdata;
                            end
                        end
                    end
                end
                if (bus.resp_valid) begin
                    if (resp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_resp: got rdata %h err %b, none expected", bus.resp_rdata, bus.resp_err);
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_rdata", 64'(bus.resp_rdata), 64'(r.rdata));
                        chk("resp_err",   64'(bus.resp_err),   64'(r.err));
                        chk("resp_cycle", 64'(cyc),            64'(r.cyc));
                    end
                end
            end
        end
    end

    task automatic exp_beat(input logic [31:0] addr, input logic [3:0] be, input logic wr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        beat_t b;
        b.addr = addr; b.be = be; b.wr = wr; b.wdata = wdata; b.rdata = rdata;
        beat_q.push_back(b);
    endtask

    // Wait (bounded) until the scoreboard has drained; lands at posedge+1 in IDLE.
    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (beat_q.size() == 0 && resp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (beat_q.size() != 0 || resp_q.size() != 0) begin
            chk("drain_timeout", 64'(beat_q.size() + resp_q.size()), 64'd0);
            beat_q.delete();
            resp_q.delete();
        end
    endtask

    // Issue one request at posedge+1 in IDLE; optional stall of the second beat.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input int stall);
        resp_t r;
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.cyc   = cyc + lat + stall;
        resp_q.push_back(r);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        if (stall > 0) begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            for (int i = 0; i < stall; i++) @(posedge clk);
            #1;
            bus.mem_ready = 1'b1;
        end
        wait_drain();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rd_pend  = 1'b0;
        rd_val   = 32'h0;
        reset    = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",  64'(bus.req_ready),  64'd1);
        chk("rst_mem_valid",  64'(bus.mem_valid),  64'd0);
        chk("rst_mem_be",     64'(bus.mem_be),     64'd0);
        chk("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
        @(posedge clk);
        #1;

        // lw aligned
        exp_beat(32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0);
        // lb / lbu at byte 3
        exp_beat(32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h8012_3456);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0);
        exp_beat(32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h8012_3456);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0, 3, 0);
        // lh sign-extended, lhu at odd offset inside one word
        exp_beat(32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'hFEDC_1234);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_FEDC, 1'b0, 3, 0);
        exp_beat(32'h0000_0100, 4'b0110, 1'b0, 32'h0, 32'h00AB_CD00);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_ABCD, 1'b0, 3, 0);
        // split lw
        exp_beat(32'h0000_00FC, 4'b1100, 1'b0, 32'h0, 32'hBBAA_0000);
        exp_beat(32'h0000_0100, 4'b0011, 1'b0, 32'h0, 32'h0000_DDCC);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_00FE, 32'h0, 32'hDDCC_BBAA, 1'b0, 4, 0);
        // split sh
        exp_beat(32'h0000_00FC, 4'b1000, 1'b1, 32'h3400_0000, 32'h0);
        exp_beat(32'h0000_0100, 4'b0001, 1'b1, 32'h0000_0012, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_00FF, 32'h0000_1234, 32'h0, 1'b0, 3, 0);
        // aligned sb
        exp_beat(32'h0000_0100, 4'b0010, 1'b1, 32'h0000_A700, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_00A7, 32'h0, 1'b0, 2, 0);
        // split lw with 3-cycle stall on beat 1
        exp_beat(32'h0000_00FC, 4'b1100, 1'b0, 32'h0, 32'h5566_0000);
        exp_beat(32'h0000_0100, 4'b0011, 1'b0, 32'h0, 32'h0000_7788);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_00FE, 32'h0, 32'h7788_5566, 1'b0, 4, 3);
        // size 3 on a 32-bit datapath: no beats, error response
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 1, 0);
        // sw crossing the top of the address space wraps beat 1 to 0
        exp_beat(32'hFFFF_FFFC, 4'b1100, 1'b1, 32'hF00D_0000, 32'h0);
        exp_beat(32'h0000_0000, 4'b0011, 1'b1, 32'h0000_CAFE, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 0);

        // reset asserted while beat 1 is stalled
        exp_beat(32'h0000_00FC, 4'b1100, 1'b0, 32'h0, 32'h9988_0000);
        exp_beat(32'h0000_0100, 4'b0011, 1'b0, 32'h0, 32'h0000_1122);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0000_00FE;
        bus.req_wdata    = 32'h0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        beat_q.delete();
        rd_pend = 1'b0;
        @(negedge clk);
        chk("midrst_mem_valid",  64'(bus.mem_valid),  64'd0);
        chk("midrst_req_ready",  64'(bus.req_ready),  64'd1);
        chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // recovery after reset
        exp_beat(32'h0000_0300, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1'b0, 3, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
